// File: rtl/e_mdu.sv
// E-stage multiply/divide unit for the P6 pipeline.
// Owns HI/LO, runs mult/div over a fixed latency and reports Start/Busy.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  EMDUOp,
    input  logic [31:0] EA,
    input  logic [31:0] EB,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUResult
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;

    logic        is_md;
    logic        is_mult;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] dvs_s;
    logic [31:0] dvs_u;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        res_we;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign is_md   = (EMDUOp >= OP_MULT) && (EMDUOp <= OP_DIVU);
    assign is_mult = (EMDUOp == OP_MULT) || (EMDUOp == OP_MULTU);
    assign Start   = is_md && !busy_q;
    assign Busy    = busy_q;
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign cnt_d   = cnt_q - 4'd1;

    always_comb begin
        MDUResult = 32'd0;
        if (EMDUOp == OP_MFHI) begin
            MDUResult = hi_q;
        end else if (EMDUOp == OP_MFLO) begin
            MDUResult = lo_q;
        end
    end

    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide on magnitudes; INT_MIN / -1 wraps back to INT_MIN.
    assign abs_a = a_q[31] ? (32'd0 - a_q) : a_q;
    assign abs_b = b_q[31] ? (32'd0 - b_q) : b_q;
    assign dvs_s = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign dvs_u = (b_q == 32'd0) ? 32'd1 : b_q;
    assign uq_s  = abs_a / dvs_s;
    assign ur_s  = abs_a % dvs_s;
    assign q_s   = (a_q[31] ^ b_q[31]) ? (32'd0 - uq_s) : uq_s;
    assign r_s   = a_q[31] ? (32'd0 - ur_s) : ur_s;
    assign q_u   = a_q / dvs_u;
    assign r_u   = a_q % dvs_u;

    always_comb begin
        res_we = 1'b0;
        res_hi = hi_q;
        res_lo = lo_q;
        unique case (op_q)
            OP_MULT: begin
                res_we = 1'b1;
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_we = 1'b1;
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_we = (b_q != 32'd0);
                res_hi = r_s;
                res_lo = q_s;
            end
            OP_DIVU: begin
                res_we = (b_q != 32'd0);
                res_hi = r_u;
                res_lo = q_u;
            end
            default: begin
                res_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        op_q    <= EMDUOp;
                        a_q     <= EA;
                        b_q     <= EB;
                        cnt_q   <= is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else if (EMDUOp == OP_MTHI) begin
                        hi_q <= EA;
                    end else if (EMDUOp == OP_MTLO) begin
                        lo_q <= EA;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == 4'd1) begin
                        if (res_we) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: scoreboard of expected HI/LO pairs,
// checked with immediate assertions when Busy falls.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  EMDUOp;
    logic [31:0] EA;
    logic [31:0] EB;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUResult;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    e_mdu dut (
        .clk(clk),
        .reset(reset),
        .EMDUOp(EMDUOp),
        .EA(EA),
        .EB(EB),
        .Start(Start),
        .Busy(Busy),
        .HI(HI),
        .LO(LO),
        .MDUResult(MDUResult)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        EMDUOp = op;
        EA     = a;
        EB     = b;
    endtask

    // Counts negedges with Busy high, bounded so a stuck Busy cannot hang.
    task automatic wait_idle(input int start_n, output int n);
        n = start_n;
        while (Busy === 1'b1 && n < 30) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [63:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, HI, e[63:32]);
            chk({tag, "_lo"}, LO, e[31:0]);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int ncyc, input logic [63:0] exp);
        int n;
        @(negedge clk);
        sb.push_back(exp);
        drive(op, a, b);
        #1 chk({tag, "_start"}, 32'(Start), 32'd1);
        @(negedge clk);
        drive(4'd0, 32'd0, 32'd0);
        wait_idle(0, n);
        chk({tag, "_busycyc"}, 32'(n), 32'(ncyc));
        sb_check(tag);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(4'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_start", 32'(Start), 32'd0);
        reset = 1'b0;

        run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5,
               {32'hFFFFFFFF, 32'hFFFFFFFA});
        run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5,
               {32'h00000002, 32'hFFFFFFFA});
        run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10,
               {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("divu", 4'd4, 32'd7, 32'd2, 10, {32'd1, 32'd3});

        @(negedge clk);
        drive(4'd7, 32'h12345678, 32'd0);
        @(negedge clk);
        drive(4'd8, 32'h9ABCDEF0, 32'd0);
        #1 chk("mthi_vis", HI, 32'h12345678);
        @(negedge clk);
        drive(4'd0, 32'd0, 32'd0);
        chk("mtlo_vis", LO, 32'h9ABCDEF0);
        run_op("div0", 4'd3, 32'd5, 32'd0, 10,
               {32'h12345678, 32'h9ABCDEF0});
        run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10,
               {32'h00000000, 32'h80000000});

        // Illegal issue while busy must be ignored
        @(negedge clk);
        sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
        drive(4'd1, 32'hFFFFFFFE, 32'd3);
        #1 chk("bsy_start", 32'(Start), 32'd1);
        @(negedge clk);
        drive(4'd8, 32'h0000DEAD, 32'd0);
        #1 chk("bsy_mtlo_nostart", 32'(Start), 32'd0);
        @(negedge clk);
        drive(4'd3, 32'd100, 32'd7);
        #1 chk("bsy_div_nostart", 32'(Start), 32'd0);
        @(negedge clk);
        drive(4'd0, 32'd0, 32'd0);
        wait_idle(2, n);
        chk("bsy_busycyc", 32'(n), 32'd5);
        sb_check("bsy");

        // Back-to-back issue in the cycle Busy falls
        sb.push_back({32'd0, 32'd6});
        drive(4'd2, 32'd2, 32'd3);
        #1 chk("b2b_start", 32'(Start), 32'd1);
        @(negedge clk);
        drive(4'd0, 32'd0, 32'd0);
        wait_idle(0, n);
        chk("b2b_busycyc", 32'(n), 32'd5);
        sb_check("b2b");

        // Asynchronous reset in the third busy cycle of a div
        @(negedge clk);
        drive(4'd3, 32'd100, 32'd7);
        @(negedge clk);
        drive(4'd0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("rstmid_busy", 32'(Busy), 32'd0);
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);
        #1 reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rstpost_busy", 32'(Busy), 32'd0);
        chk("rstpost_hi", HI, 32'd0);
        chk("rstpost_lo", LO, 32'd0);

        // mfhi / mflo readback
        drive(4'd8, 32'h00000055, 32'd0);
        @(negedge clk);
        drive(4'd7, 32'hAAAA0000, 32'd0);
        @(negedge clk);
        drive(4'd5, 32'd0, 32'd0);
        #1 chk("mfhi", MDUResult, 32'hAAAA0000);
        @(negedge clk);
        drive(4'd6, 32'd0, 32'd0);
        #1 chk("mflo", MDUResult, 32'h00000055);
        @(negedge clk);
        for (int op = 0; op < 16; op++) begin
            if (op == 0 || op >= 9) begin
                drive(4'(op), 32'hFFFFFFFF, 32'hFFFFFFFF);
                #1 chk($sformatf("nop%0d_res", op), MDUResult, 32'd0);
                chk($sformatf("nop%0d_start", op), 32'(Start), 32'd0);
                @(negedge clk);
            end
        end
        drive(4'd0, 32'd0, 32'd0);
        chk("nop_hi", HI, 32'hAAAA0000);
        chk("nop_lo", LO, 32'h00000055);
        chk("nop_busy", 32'(Busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the P6 pipeline. It consumes the forwarded E-stage operands, which are the D-stage forwarded register values after they pass through the D/E register. It runs mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO architectural registers. It reports `Start`/`Busy` to the hazard unit so that any later MDU instruction stalls in D until the unit is free.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `EMDUOp`  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9–15 none.
- `EA`  in  32  forwarded rs value (E stage).
- `EB`  in  32  forwarded rt value (E stage).
- `Start`  out  1  combinational; 1 when `EMDUOp` ∈ {1..4} and `Busy`=0.
- `Busy`  out  1  registered; 1 while an operation is in flight.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.
- `MDUResult`  out  32  combinational; `HI` when op=5, `LO` when op=6, else 0.

## Operation
- States: IDLE and RUN. There is one 4-bit down-counter `cnt`, plus latched op, `EA` and `EB`.
- IDLE, when `Start`=1 at the edge:
  - latch op, `EA`, `EB`;
  - load `cnt` = `MULT_CYCLES` or `DIV_CYCLES`;
  - go to RUN and set `Busy`=1.
- RUN:
  - `cnt` decrements each edge.
  - At the edge where `cnt`=1: write HI/LO, clear `Busy`, return to IDLE.
- Arithmetic is on the latched operands:
  - mult: signed 32×32→64; HI = [63:32], LO = [31:0].
  - multu: the same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero: HI and LO are left unchanged. The operation still occupies the full `DIV_CYCLES`.
- mthi/mtlo (op 7/8) in IDLE: HI or LO ← `EA` at that edge, single cycle, `Busy` stays 0.
- mfhi/mflo: `MDUResult` reads the current register value. There is no internal bypass from a same-cycle mthi/mtlo.
- Ops 1–8 arriving while `Busy`=1 are ignored. The hazard unit must not issue them; the bench treats any such occurrence as a hazard-unit error and checks that HI/LO and `cnt` stay unaffected.
- Ops 0 and 9–15: no effect.
- Reset, including mid-RUN: HI=0, LO=0, `Busy`=0, `cnt`=0, state IDLE, latched operands 0. An in-flight result is discarded.

## Timing
- Hazard stall condition: stall D when the D instruction is an MDU op and (`Start` | `Busy`).
- A mult issued in E in cycle t (Start=1):
  - `Busy`=1 for cycles t+1 … t+5;
  - HI/LO are updated at the end of t+5;
  - `Busy`=0 in t+6.
  - An mfhi in E in t+6 reads the new HI.
- A div issued in cycle t: `Busy`=1 for t+1 … t+10; the new HI/LO are visible in t+11.
- `Start` depends on `Busy` only as registered, so there is no combinational loop with the stall logic.
- A new mult/div is accepted in the same cycle `Busy` falls (cycle t+6 / t+11), giving back-to-back issue with no bubble.
- mthi/mtlo in cycle t: the value is visible on HI/LO in t+1.

## Test plan
- Signed multiply: mult, EA=0xFFFFFFFE (−2), EB=3.
  - Required: `Busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Follow-up: multu on the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- Signed divide: div, EA=0xFFFFFFF9 (−7), EB=2.
  - Required: after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Follow-up: divu, EA=7, EB=2 gives LO=3, HI=1.
- Divide by zero and overflow:
  - mthi 0x12345678, mtlo 0x9ABCDEF0, then div EA=5, EB=0: `Busy` runs 10 cycles and HI/LO are unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Issue while busy and back-to-back:
  - During a mult, drive mtlo 0xDEAD and div: both are ignored and the mult result lands at t+5.
  - Drive multu 2×3 in the cycle `Busy` falls: it is accepted with `Start`=1, giving LO=6 five cycles later.
- Reset mid-operation: assert `reset` asynchronously (between clock edges) in cycle 3 of a div.
  - Required: `Busy`, HI and LO go to 0 immediately, and no write occurs after reset is released.
- mfhi/mflo readback: mthi 0xAAAA0000, then mfhi the next cycle, then mflo.
  - Required: `MDUResult`=0xAAAA0000, then the current LO; `MDUResult`=0 for ops 0 and 9–15.
